pq_init: RTL and testbench

PQ_INIT -- requirements
Module: pq_init

---
 rtl/pq_init.sv | 145 ++++++++++++++
 tb/tb_pq_init.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pq_init.sv
// Priority-queue initiator: fills a PQ device with LFSR-keyed items, drains it,
// and flags ordering, overflow and count errors.
module pq_init #(
   parameter int unsigned KW   = 16,
   parameter int unsigned VW   = 8,
   parameter int unsigned NOPS = 32,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             enq,
   output logic             deq,
   output logic [KW+VW-1:0] kvi,
   input  logic [KW+VW-1:0] kvo,
   input  logic             busy,
   input  logic             full,
   input  logic             empty,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_cnt
);

   localparam int unsigned KVW = KW + VW;
   localparam int unsigned CW  = VW + 1;

   typedef enum logic [2:0] {IDLE, FILL, WAITF, DRAIN, WAITD, DONE} state_t;

   state_t          state_q, state_d;
   logic [15:0]     lfsr_q, lfsr_d, lfsr_adv;
   logic [VW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   dcnt_q, dcnt_d;
   logic [KW-1:0]   last_key_q, last_key_d;
   logic            seen_q, seen_d;
   logic [7:0]      err_d;
   logic [KVW-1:0]  kvi_d;
   logic            enq_d, deq_d, done_d, pass_d;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lfsr_q     <= SEED;
         idx_q      <= '0;
         dcnt_q     <= '0;
         last_key_q <= '0;
         seen_q     <= 1'b0;
         err_cnt    <= '0;
         kvi        <= '0;
         enq        <= 1'b0;
         deq        <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         idx_q      <= idx_d;
         dcnt_q     <= dcnt_d;
         last_key_q <= last_key_d;
         seen_q     <= seen_d;
         err_cnt    <= err_d;
         kvi        <= kvi_d;
         enq        <= enq_d;
         deq        <= deq_d;
         done       <= done_d;
         pass       <= pass_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      idx_d      = idx_q;
      dcnt_d     = dcnt_q;
      last_key_d = last_key_q;
      seen_d     = seen_q;
      err_d      = err_cnt;
      kvi_d      = kvi;
      enq_d      = 1'b0;
      deq_d      = 1'b0;
      lfsr_adv   = lfsr_step(lfsr_q);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lfsr_d     = SEED;
               idx_d      = '0;
               dcnt_d     = '0;
               last_key_d = '0;
               seen_d     = 1'b0;
               err_d      = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (!busy) begin
               if (full) begin
                  err_d   = sat_inc(err_cnt);
                  state_d = DRAIN;
               end else begin
                  enq_d   = 1'b1;
                  kvi_d   = {KW'(lfsr_adv), idx_q};
                  lfsr_d  = lfsr_adv;
                  idx_d   = idx_q + VW'(1);
                  state_d = WAITF;
               end
            end
         end
         WAITF: state_d = (idx_q < VW'(NOPS)) ? FILL : DRAIN;
         DRAIN: begin
            if (!busy) begin
               if (!empty) begin
                  // whole-word compare against {last_key, 0} is exactly key < last_key
                  if (seen_q && (kvo < {last_key_q, VW'(0)}))
                     err_d = sat_inc(err_cnt);
                  last_key_d = kvo[KVW-1:VW];
                  seen_d     = 1'b1;
                  dcnt_d     = dcnt_q + CW'(1);
                  deq_d      = 1'b1;
                  state_d    = WAITD;
               end else begin
                  if (dcnt_q != CW'(idx_q))
                     err_d = sat_inc(err_cnt);
                  state_d = DONE;
               end
            end
         end
         WAITD: state_d = DRAIN;
         default: state_d = IDLE;
      endcase

      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == 8'd0);
   end

endmodule

// File: tb/tb_pq_init.sv
// Bench for pq_init: behavioural PQ device plus a per-cycle reference model of
// the enqueue stream, dequeue ordering and expected error count.
module tb_pq_init;

   localparam int unsigned KW   = 16;
   localparam int unsigned VW   = 8;
   localparam int unsigned KVW  = KW + VW;
   localparam int unsigned NOPS = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           enq, deq, done, pass;
   logic [KVW-1:0] kvi;
   logic [KVW-1:0] kvo = '0;
   logic           busy = 1'b0, full = 1'b0, empty = 1'b1;
   logic [7:0]     err_cnt;

   pq_init #(.KW(KW), .VW(VW), .NOPS(NOPS), .SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .enq(enq), .deq(deq),
      .kvi(kvi), .kvo(kvo), .busy(busy), .full(full), .empty(empty),
      .done(done), .pass(pass), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Key of the k-th enqueued item: LFSR advanced k+1 times from the seed
   function automatic logic [15:0] ref_key(input int k);
      logic [15:0] l = 16'hACE1;
      for (int i = 0; i <= k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      return l;
   endfunction

   // PQ device configuration and state
   int             depth = 64;
   int             busy_len = 0;
   bit             fault = 1'b0;
   int             busy_cnt = 0;
   logic [KVW-1:0] pq[$];

   // Reference model state
   int             enq_n = 0, deq_n = 0, ord_err = 0;
   logic [KW-1:0]  mlast = '0;
   bit             mseen = 1'b0, in_run = 1'b0;
   logic [KVW-1:0] last_kvi = '0, first_kvi = '0;

   function automatic int head_sel();
      return (fault && deq_n == 2 && pq.size() > 1) ? 1 : 0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk(enq == 1'b0 && deq == 1'b0, "strobe_in_reset", {enq, deq}, 0);
         pq.delete();
         busy_cnt = 0;
         enq_n = 0; deq_n = 0; ord_err = 0;
         mseen = 1'b0; in_run = 1'b0; last_kvi = '0;
      end else begin
         if (start && !in_run) begin
            in_run = 1'b1; enq_n = 0; deq_n = 0; ord_err = 0; mseen = 1'b0;
         end
         chk(!(enq && deq), "enq_deq_overlap", {enq, deq}, 0);
         chk(!(busy && (enq || deq)), "strobe_while_busy", {busy, enq, deq}, 0);
         if (!done) chk(pass == 1'b0, "pass_outside_done", pass, 0);
         if ((enq || deq) && !in_run) chk(1'b0, "strobe_without_run", {enq, deq}, 0);
         if (enq) begin
            logic [KVW-1:0] exp_kv;
            int pos;
            exp_kv = {ref_key(enq_n), 8'(enq_n)};
            chk(kvi == exp_kv, "enq_kvi", kvi, exp_kv);
            chk(enq_n < NOPS, "enq_overrun", enq_n, NOPS);
            if (enq_n == 0) first_kvi = kvi;
            last_kvi = kvi;
            enq_n++;
            if (pq.size() >= depth) chk(1'b0, "enq_when_full", pq.size(), depth);
            else begin
               pos = pq.size();
               for (int i = pq.size() - 1; i >= 0; i--)
                  if (pq[i][KVW-1:VW] > kvi[KVW-1:VW]) pos = i;
               pq.insert(pos, kvi);
            end
         end else begin
            chk(kvi == last_kvi, "kvi_hold", kvi, last_kvi);
         end
         if (deq) begin
            if (pq.size() == 0) chk(1'b0, "deq_when_empty", deq_n, 0);
            else begin
               int s;
               logic [KW-1:0] k;
               s = head_sel();
               k = pq[s][KVW-1:VW];
               if (mseen && k < mlast) ord_err++;
               mlast = k; mseen = 1'b1;
               pq.delete(s);
               deq_n++;
            end
         end
         if (enq || deq) busy_cnt = busy_len;
         else if (busy_cnt > 0) busy_cnt--;
         if (done && !start) in_run = 1'b0;
      end
      empty = (pq.size() == 0);
      full  = (pq.size() >= depth);
      kvo   = empty ? '0 : pq[head_sel()];
      busy  = (busy_cnt != 0);
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input int d, input bit f, input int bl, input bit mid,
                      input int xe, input int xd, input int xerr, input bit xpass,
                      input string tag);
      int cyc;
      int me;
      depth = d; fault = f; busy_len = bl;
      pulse_start();
      if (mid) begin
         repeat (3) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk(done == 1'b1, {tag, "_done"}, done, 1);
      me = ord_err + ((enq_n < NOPS) ? 1 : 0) + ((deq_n != enq_n) ? 1 : 0);
      if (me > 255) me = 255;
      chk(err_cnt == 8'(xerr), {tag, "_err_cnt"}, err_cnt, xerr);
      chk(err_cnt == 8'(me), {tag, "_err_cnt_model"}, err_cnt, me);
      chk(pass == xpass, {tag, "_pass"}, pass, xpass);
      chk(enq_n == xe, {tag, "_enq_count"}, enq_n, xe);
      chk(deq_n == xd, {tag, "_deq_count"}, deq_n, xd);
   endtask

   initial begin
      int cyc;
      repeat (3) @(posedge clk);
      #1;
      chk(enq == 1'b0, "rst_enq", enq, 0);
      chk(deq == 1'b0, "rst_deq", deq, 0);
      chk(kvi == '0, "rst_kvi", kvi, 0);
      chk(done == 1'b0, "rst_done", done, 0);
      chk(pass == 1'b0, "rst_pass", pass, 0);
      chk(err_cnt == 8'd0, "rst_err_cnt", err_cnt, 0);
      chk(ref_key(0) == 16'h59C3, "ref_lfsr_first", ref_key(0), 16'h59C3);
      rst_n = 1'b1;

      run(64, 1'b0, 0, 1'b1, 32, 32, 0, 1'b1, "normal");
      chk(first_kvi == 24'h59C300, "first_kvi", first_kvi, 24'h59C300);
      run(8,  1'b0, 0, 1'b0, 8,  8,  1, 1'b0, "overflow");
      run(64, 1'b1, 0, 1'b0, 32, 32, 1, 1'b0, "swap");
      run(64, 1'b0, 5, 1'b0, 32, 32, 0, 1'b1, "busy");

      // abort a run partway through the drain
      depth = 64; fault = 1'b0; busy_len = 0;
      pulse_start();
      cyc = 0;
      while (deq_n < 5 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk(deq_n >= 5, "reach_drain", deq_n, 5);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk(enq == 1'b0, "abort_enq", enq, 0);
      chk(deq == 1'b0, "abort_deq", deq, 0);
      chk(done == 1'b0, "abort_done", done, 0);
      chk(err_cnt == 8'd0, "abort_err_cnt", err_cnt, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      run(64, 1'b0, 0, 1'b0, 32, 32, 0, 1'b1, "after_abort");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
